riscv_core_mdu_iter: RTL and testbench

Parametrised iterative RV64M/RV32M multiply/divide unit with a valid/ready request and response handshake, flush, and a held result register. Multiply retires MUL_STEP multiplier bits per cycle; divide is restoring, one quotient bit per cycle. Divide-by-zero and signed overflow resolve on a one-cycle fast path. It sits in the execute stage beside the ALU and stalls issue through `o_mdu_ready`.

---
 rtl/riscv_core_mdu_iter.sv | 174 +++++++++++++++++
 tb/tb_riscv_core_mdu_iter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_mdu_iter.sv
// riscv_core_mdu_iter: iterative RV64M/RV32M multiply/divide unit (MUL_STEP bits/cycle multiply,
// restoring divide, one-cycle divide-by-zero/overflow path). Option: RISCV_CORE_MDU_EARLY_TERM_EN.
module riscv_core_mdu_iter #(
    parameter int XLEN     = 64,
    parameter int MUL_STEP = 4
) (
    input  logic            i_mdu_clk,
    input  logic            i_mdu_rstn,
    input  logic            i_mdu_valid,
    output logic            o_mdu_ready,
    input  logic [2:0]      i_mdu_control,
    input  logic            i_mdu_isword,
    input  logic [XLEN-1:0] i_mdu_srcA,
    input  logic [XLEN-1:0] i_mdu_srcB,
    input  logic            i_mdu_flush,
    output logic            o_mdu_valid,
    input  logic            i_mdu_ready,
    output logic [XLEN-1:0] o_mdu_result,
    output logic            o_mdu_div_by_zero,
    output logic            o_mdu_overflow
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam int PW = 2 * XLEN;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
    state_t state, state_nxt;

    // acc holds the running product, or {remainder, dividend/quotient} while dividing
    logic [PW-1:0]   acc, mcand;
    logic [XLEN-1:0] opb, res_q;
    logic [CW-1:0]   cnt;
    logic [2:0]      ctrl_q;
    logic            word_q, neg_p, neg_r, dbz_q, ovf_q;

    logic            accept, word, sgn_a, sgn_b, is_div, neg_a, neg_b, dbz, ovf, fast;
    logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_neg, a_res, fast_res;
    logic [CW-1:0]   n_init;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v, input logic s);
        logic [XLEN-1:0] r;
        r = {XLEN{s & v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    assign o_mdu_ready       = (state == S_IDLE);
    assign o_mdu_valid       = (state == S_DONE);
    assign o_mdu_result      = res_q;
    assign o_mdu_div_by_zero = dbz_q;
    assign o_mdu_overflow    = ovf_q;
    assign accept            = i_mdu_valid && o_mdu_ready && !i_mdu_flush;

    always_comb begin
        word   = (XLEN == 64) && i_mdu_isword;
        is_div = i_mdu_control[2];
        sgn_a  = 1'b0;
        sgn_b  = 1'b0;
        case (i_mdu_control)
            3'b000, 3'b001, 3'b100, 3'b110: begin sgn_a = 1'b1; sgn_b = 1'b1; end
            3'b010:                         sgn_a = 1'b1;
            default: ;
        endcase
        a_ext   = word ? sext32(i_mdu_srcA[31:0], sgn_a) : i_mdu_srcA;
        b_ext   = word ? sext32(i_mdu_srcB[31:0], sgn_b) : i_mdu_srcB;
        neg_a   = sgn_a & a_ext[XLEN-1];
        neg_b   = sgn_b & b_ext[XLEN-1];
        mag_a   = neg_a ? -a_ext : a_ext;
        mag_b   = neg_b ? -b_ext : b_ext;
        min_neg = word ? sext32(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
        dbz     = is_div && (b_ext == '0);
        ovf     = is_div && sgn_a && !dbz && (a_ext == min_neg) && (&b_ext);
        fast    = dbz || ovf;
        // dividend returned by the fast path is always sign-extended from the word
        a_res   = word ? sext32(i_mdu_srcA[31:0], 1'b1) : i_mdu_srcA;
        if (dbz) fast_res = i_mdu_control[1] ? a_res : '1;
        else     fast_res = i_mdu_control[1] ? '0 : a_res;
        if (is_div) n_init = word ? CW'(32) : CW'(XLEN);
        else        n_init = word ? CW'(32 / MUL_STEP) : CW'(XLEN / MUL_STEP);
    end

    logic [PW-1:0]   mul_pp;
    logic [XLEN:0]   rem_sh, rem_sub;
    logic            mul_last;

    assign mul_pp  = mcand * PW'(opb[MUL_STEP-1:0]);
    assign rem_sh  = {acc[PW-1:XLEN], acc[XLEN-1]};
    assign rem_sub = rem_sh - {1'b0, opb};

`ifdef RISCV_CORE_MDU_EARLY_TERM_EN
    assign mul_last = (cnt == CW'(1)) || ((opb >> MUL_STEP) == '0);
`else
    assign mul_last = (cnt == CW'(1));
`endif

    logic [PW-1:0]   prod;
    logic [XLEN-1:0] quo, rmd, fix_v, fix_res;

    always_comb begin
        prod = neg_p ? -acc : acc;
        quo  = neg_p ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rmd  = neg_r ? -acc[PW-1:XLEN] : acc[PW-1:XLEN];
        if (ctrl_q[2])                 fix_v = ctrl_q[1] ? rmd : quo;
        else if (ctrl_q[1:0] == 2'b00) fix_v = prod[XLEN-1:0];
        else if (word_q)               fix_v = sext32(prod[63:32], 1'b1);
        else                           fix_v = prod[PW-1:XLEN];
        fix_res = word_q ? sext32(fix_v[31:0], 1'b1) : fix_v;
    end

    always_ff @(posedge i_mdu_clk or negedge i_mdu_rstn) begin
        if (!i_mdu_rstn) state <= S_IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (i_mdu_flush) state_nxt = S_IDLE;
        else begin
            case (state)
                S_IDLE: if (accept) state_nxt = fast ? S_DONE : (is_div ? S_DIV : S_MUL);
                S_MUL:  if (mul_last) state_nxt = S_FIX;
                S_DIV:  if (cnt == CW'(1)) state_nxt = S_FIX;
                S_FIX:  state_nxt = S_DONE;
                S_DONE: if (i_mdu_ready) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_mdu_clk or negedge i_mdu_rstn) begin
        if (!i_mdu_rstn) begin
            acc    <= '0;
            mcand  <= '0;
            opb    <= '0;
            res_q  <= '0;
            cnt    <= '0;
            ctrl_q <= '0;
            word_q <= 1'b0;
            neg_p  <= 1'b0;
            neg_r  <= 1'b0;
            dbz_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    ctrl_q <= i_mdu_control;
                    word_q <= word;
                    neg_p  <= neg_a ^ neg_b;
                    neg_r  <= neg_a;
                    dbz_q  <= dbz;
                    ovf_q  <= ovf;
                    cnt    <= n_init;
                    opb    <= mag_b;
                    mcand  <= {{XLEN{1'b0}}, mag_a};
                    // word dividends are parked in the top half so W shifts bring every bit through
                    acc    <= is_div ? {{XLEN{1'b0}}, (word ? mag_a << (XLEN - 32) : mag_a)} : '0;
                    if (fast) res_q <= fast_res;
                end
                S_MUL: begin
                    acc   <= acc + mul_pp;
                    mcand <= mcand << MUL_STEP;
                    opb   <= opb >> MUL_STEP;
                    cnt   <= cnt - CW'(1);
                end
                S_DIV: begin
                    acc <= {(rem_sub[XLEN] ? rem_sh[XLEN-1:0] : rem_sub[XLEN-1:0]),
                            acc[XLEN-2:0], ~rem_sub[XLEN]};
                    cnt <= cnt - CW'(1);
                end
                S_FIX: if (!i_mdu_flush) res_q <= fix_res;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_core_mdu_iter.sv
// tb_riscv_core_mdu_iter: scoreboard bench for riscv_core_mdu_iter at XLEN=64, MUL_STEP=4.
`timescale 1ns/1ps
module tb_riscv_core_mdu_iter;
`ifdef RISCV_CORE_MDU_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif
    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3,
                           DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic        valid = 1'b0, ready = 1'b1, isword = 1'b0, flush = 1'b0;
    logic [2:0]  ctrl = 3'd0;
    logic [63:0] srca = '0, srcb = '0;
    logic        o_mdu_ready, o_mdu_valid, o_mdu_div_by_zero, o_mdu_overflow;
    logic [63:0] o_mdu_result;

    typedef struct {
        logic [63:0] res;
        logic        dz;
        logic        ov;
        int          lat;
        int          t0;
    } exp_t;

    exp_t  sb[$];
    string tq[$];
    exp_t  mon_e;
    string mon_t;
    int    total = 0, bad = 0, cyc = 0;

    riscv_core_mdu_iter #(.XLEN(64), .MUL_STEP(4)) dut (
        .i_mdu_clk(clk), .i_mdu_rstn(rst_n), .i_mdu_valid(valid), .o_mdu_ready(o_mdu_ready),
        .i_mdu_control(ctrl), .i_mdu_isword(isword), .i_mdu_srcA(srca), .i_mdu_srcB(srcb),
        .i_mdu_flush(flush), .o_mdu_valid(o_mdu_valid), .i_mdu_ready(ready),
        .o_mdu_result(o_mdu_result), .o_mdu_div_by_zero(o_mdu_div_by_zero),
        .o_mdu_overflow(o_mdu_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // lat = edges after the accept edge until valid; -1 marks a fast-path op (valid right after accept)
    task automatic issue(input string tag, input logic [2:0] c, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] er,
                         input logic edz, input logic eov, input int lat, input bit push);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!o_mdu_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!o_mdu_ready) begin
            chk({tag, "_acc_timeout"}, 64'd0, 64'd1);
            return;
        end
        ctrl = c; isword = w; srca = a; srcb = b; valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        srca = $urandom; srcb = $urandom; ctrl = 3'($urandom);
        if (push) begin
            e.res = er; e.dz = edz; e.ov = eov; e.lat = lat; e.t0 = cyc;
            sb.push_back(e);
            tq.push_back(tag);
        end
        if (lat < 0) begin
            @(negedge clk);
            chk({tag, "_fast_vld"}, 64'(o_mdu_valid), 64'd1);
        end
    endtask

    task automatic wait_sb();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("sb_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
            tq.delete();
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && o_mdu_valid && ready) begin
            if (sb.size() == 0) chk("spurious_vld", 64'd1, 64'd0);
            else begin
                mon_e = sb.pop_front();
                mon_t = tq.pop_front();
                chk({mon_t, "_res"}, o_mdu_result, mon_e.res);
                chk({mon_t, "_dz"}, 64'(o_mdu_div_by_zero), 64'(mon_e.dz));
                chk({mon_t, "_ov"}, 64'(o_mdu_overflow), 64'(mon_e.ov));
                if (mon_e.lat >= 0) chk({mon_t, "_lat"}, 64'(cyc - mon_e.t0), 64'(mon_e.lat));
            end
        end
    end

    initial begin
        bit seen;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(o_mdu_ready), 64'd1);
        chk("rst_valid", 64'(o_mdu_valid), 64'd0);
        chk("rst_result", o_mdu_result, 64'd0);
        chk("rst_dz", 64'(o_mdu_div_by_zero), 64'd0);
        chk("rst_ov", 64'(o_mdu_overflow), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        issue("mul", MUL, 0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 0, 0, ET ? 2 : 17, 1);
        wait_sb();
        issue("mulh", MULH, 0, MINN, MINN, 64'h4000_0000_0000_0000, 0, 0, 17, 1);
        wait_sb();
        issue("mulhu", MULHU, 0, ONES, 64'd2, 64'd1, 0, 0, ET ? 2 : 17, 1);
        wait_sb();
        issue("mulhsu", MULHSU, 0, ONES, ONES, ONES, 0, 0, 17, 1);
        wait_sb();
        issue("mulw", MUL, 1, 64'hDEAD_BEEF_7FFF_FFFF, 64'd3, 64'h0000_0000_7FFF_FFFD, 0, 0, ET ? 2 : 9, 1);
        wait_sb();
        issue("mulw_neg", MUL, 1, 64'd5, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 0, 0, ET ? 2 : 9, 1);
        wait_sb();
        issue("div_z", DIV, 0, 64'd7, 64'd0, ONES, 1, 0, -1, 1);
        wait_sb();
        issue("rem_z", REM, 0, 64'd7, 64'd0, 64'd7, 1, 0, -1, 1);
        wait_sb();
        issue("div_ov", DIV, 0, MINN, ONES, MINN, 0, 1, -1, 1);
        wait_sb();
        issue("rem_ov", REM, 0, MINN, ONES, 64'd0, 0, 1, -1, 1);
        wait_sb();
        issue("divw", DIV, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0, 33, 1);
        wait_sb();
        issue("remw", REM, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, ONES, 0, 0, 33, 1);
        wait_sb();
        issue("div", DIV, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 0, 0, 65, 1);
        wait_sb();
        issue("rem", REM, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 65, 1);
        wait_sb();

        // flush a DIVU ten cycles into its run
        issue("divu_fl", DIVU, 0, 64'd100, 64'd7, 64'd0, 0, 0, 65, 0);
        repeat (9) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_ready", 64'(o_mdu_ready), 64'd1);
        seen = 1'b0;
        repeat (70) begin
            @(negedge clk);
            seen |= o_mdu_valid;
        end
        chk("flush_novld", 64'(seen), 64'd0);
        issue("remu", REMU, 0, 64'd100, 64'd7, 64'd2, 0, 0, 65, 1);
        wait_sb();

        // backpressure: hold the result in DONE while inputs churn
        ready = 1'b0;
        issue("bp", DIV, 0, 64'd7, 64'd0, ONES, 1, 0, -1, 1);
        repeat (5) begin
            valid = 1'b1; srca = $urandom; srcb = 64'd0; ctrl = 3'($urandom); isword = 1'($urandom);
            @(negedge clk);
            chk("bp_res", o_mdu_result, ONES);
            chk("bp_dz", 64'(o_mdu_div_by_zero), 64'd1);
            chk("bp_ready", 64'(o_mdu_ready), 64'd0);
        end
        valid = 1'b0;
        isword = 1'b0;
        @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle", 64'(o_mdu_ready), 64'd1);
        wait_sb();

        // asynchronous reset in the middle of a multiply
        issue("mul_rst", MUL, 0, 64'd6, 64'd7, 64'd0, 0, 0, 17, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", 64'(o_mdu_ready), 64'd1);
        chk("arst_valid", 64'(o_mdu_valid), 64'd0);
        chk("arst_result", o_mdu_result, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        issue("mul_post", MUL, 0, 64'd6, 64'd7, 64'd42, 0, 0, ET ? 2 : 17, 1);
        wait_sb();

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
